// File: rtl/snake_pkg.sv
// Shared types for the snake game datapath (renderer, game logic, matrix driver).
// Contents:
//   GRID_N    - side length of the square LED matrix
//   pos_t     - {row, col} coordinate, 4 bits each
//   grid_t    - full bitmap, grid[row][col], 1 = LED on
//   rstate_e  - renderer FSM state encoding
package snake_pkg;

  localparam int GRID_N = 16;

  typedef struct packed {
    logic [3:0] row;
    logic [3:0] col;
  } pos_t;

  typedef logic [GRID_N-1:0][GRID_N-1:0] grid_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_DRAW   = 2'd2,
    ST_COMMIT = 2'd3
  } rstate_e;

endpackage

// File: rtl/snake_grid_renderer.sv
// Rasterises the snake segment list plus the food pixel into a 16x16 bitmap
// once per frame tick and publishes it atomically for the LED matrix driver.
// Self-overlap and food pickup are detected during plotting.
//
// Ports:
//   clk_i         system clock, rising edge
//   reset_i       asynchronous active-high reset
//   start_i       frame tick, only honoured in IDLE
//   snake_len_i   segments to render (head = index 0), clamped to MAX_LEN
//   food_pos_i    food {row, col}
//   food_valid_i  draw food this frame
//   seg_rd_o      segment memory read strobe
//   seg_addr_o    segment index to read (0 whenever seg_rd_o = 0)
//   seg_data_i    {row, col} of the segment requested on the previous cycle
//   grid_o        published bitmap, grid_o[row][col]
//   busy_o        high outside IDLE
//   frame_done_o  one-cycle pulse during COMMIT
//   self_hit_o    a segment landed on a pixel set by an earlier segment
//   food_eaten_o  the head landed on the food pixel
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start_i; latches length and food
// CLEAR  | one cycle: reset work buffer to the food pixel, issue read of seg 0
// DRAW   | one cycle per segment: plot seg_data_i, issue read of next index
// COMMIT | one cycle: copy work buffer and hit flags to the outputs
module snake_grid_renderer
  import snake_pkg::*;
#(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [LEN_W-1:0]   snake_len_i,
  input  logic [7:0]         food_pos_i,
  input  logic               food_valid_i,
  output logic               seg_rd_o,
  output logic [5:0]         seg_addr_o,
  input  logic [7:0]         seg_data_i,
  output logic [15:0][15:0]  grid_o,
  output logic               busy_o,
  output logic               frame_done_o,
  output logic               self_hit_o,
  output logic               food_eaten_o
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  rstate_e          state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] j_q, j_d;
  pos_t             food_q, food_d;
  logic             fv_q, fv_d;
  grid_t            work_q, work_d;
  grid_t            grid_q, grid_d;
  logic             hit_self_q, hit_self_d;
  logic             hit_food_q, hit_food_d;
  logic             self_hit_q, self_hit_d;
  logic             food_eaten_q, food_eaten_d;

  pos_t             seg;
  logic             on_food;

  assign seg     = pos_t'(seg_data_i);
  // The food pixel only exists in the buffer when food is drawn this frame.
  assign on_food = fv_q && (seg == food_q);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      j_q          <= '0;
      food_q       <= '0;
      fv_q         <= 1'b0;
      work_q       <= '0;
      grid_q       <= '0;
      hit_self_q   <= 1'b0;
      hit_food_q   <= 1'b0;
      self_hit_q   <= 1'b0;
      food_eaten_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      j_q          <= j_d;
      food_q       <= food_d;
      fv_q         <= fv_d;
      work_q       <= work_d;
      grid_q       <= grid_d;
      hit_self_q   <= hit_self_d;
      hit_food_q   <= hit_food_d;
      self_hit_q   <= self_hit_d;
      food_eaten_q <= food_eaten_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    j_d          = j_q;
    food_d       = food_q;
    fv_d         = fv_q;
    work_d       = work_q;
    grid_d       = grid_q;
    hit_self_d   = hit_self_q;
    hit_food_d   = hit_food_q;
    self_hit_d   = self_hit_q;
    food_eaten_d = food_eaten_q;
    seg_rd_o     = 1'b0;
    seg_addr_o   = '0;
    frame_done_o = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          len_d   = (snake_len_i > LEN_MAX) ? LEN_MAX : snake_len_i;
          food_d  = pos_t'(food_pos_i);
          fv_d    = food_valid_i;
          state_d = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        work_d                           = '0;
        work_d[food_q.row][food_q.col]   = fv_q;
        hit_self_d                       = 1'b0;
        hit_food_d                       = 1'b0;
        if (len_q != '0) begin
          seg_rd_o = 1'b1;
          j_d      = LEN_ONE;
          state_d  = ST_DRAW;
        end else begin
          state_d  = ST_COMMIT;
        end
      end

      ST_DRAW: begin
        // Landing on the food pixel is never an overlap: it was pre-set by CLEAR.
        if (work_q[seg.row][seg.col] && !on_food) begin
          hit_self_d = 1'b1;
        end
        if ((j_q == LEN_ONE) && on_food) begin
          hit_food_d = 1'b1;
        end
        work_d[seg.row][seg.col] = 1'b1;
        if (j_q < len_q) begin
          seg_rd_o   = 1'b1;
          seg_addr_o = j_q[5:0];
          j_d        = j_q + LEN_ONE;
        end else begin
          state_d    = ST_COMMIT;
        end
      end

      ST_COMMIT: begin
        grid_d       = work_q;
        self_hit_d   = hit_self_q;
        food_eaten_d = hit_food_q;
        frame_done_o = 1'b1;
        state_d      = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign grid_o       = grid_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign self_hit_o   = self_hit_q;
  assign food_eaten_o = food_eaten_q;

endmodule

// File: tb/tb_snake_grid_renderer.sv
module tb_snake_grid_renderer;
  import snake_pkg::*;

  typedef struct {
    grid_t g;
    logic  sh;
    logic  fe;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [6:0]       snake_len = '0;
  logic [7:0]       food_pos = '0;
  logic             food_valid = 1'b0;
  logic             seg_rd;
  logic [5:0]       seg_addr;
  logic [7:0]       seg_data = '0;
  logic [15:0][15:0] grid;
  logic             busy;
  logic             frame_done;
  logic             self_hit;
  logic             food_eaten;

  logic [7:0]       mem [0:63];
  logic [5:0]       addr_log [$];
  exp_t             sb [$];
  int               checks = 0;
  int               failures = 0;
  int               fd_cnt = 0;
  int               addr_viol = 0;

  snake_grid_renderer dut (
    .clk_i        (clk),
    .reset_i      (rst),
    .start_i      (start),
    .snake_len_i  (snake_len),
    .food_pos_i   (food_pos),
    .food_valid_i (food_valid),
    .seg_rd_o     (seg_rd),
    .seg_addr_o   (seg_addr),
    .seg_data_i   (seg_data),
    .grid_o       (grid),
    .busy_o       (busy),
    .frame_done_o (frame_done),
    .self_hit_o   (self_hit),
    .food_eaten_o (food_eaten)
  );

  always #5 clk = ~clk;

  // Synchronous segment memory: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (seg_rd) begin
      seg_data <= mem[seg_addr];
      addr_log.push_back(seg_addr);
    end
  end

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (seg_rd !== 1'b1 && seg_addr !== 6'd0) addr_viol++;
  end

  function automatic exp_t model(int len, logic [7:0] food, logic fv);
    exp_t e;
    int n;
    logic [3:0] r, c;
    e.g  = '0;
    e.sh = 1'b0;
    e.fe = 1'b0;
    if (fv) e.g[food[7:4]][food[3:0]] = 1'b1;
    n = (len > 64) ? 64 : len;
    for (int i = 0; i < n; i++) begin
      r = mem[i][7:4];
      c = mem[i][3:0];
      if (e.g[r][c] && !(fv && ({r, c} == food))) e.sh = 1'b1;
      if (i == 0 && fv && ({r, c} == food)) e.fe = 1'b1;
      e.g[r][c] = 1'b1;
    end
    return e;
  endfunction

  task automatic do_start(input int len, input logic [7:0] food, input logic fv);
    @(negedge clk);
    snake_len  = 7'(len);
    food_pos   = food;
    food_valid = fv;
    start      = 1'b1;
    sb.push_back(model(len, food, fv));
    @(negedge clk);
    start      = 1'b0;
  endtask

  // Returns negedges counted from the CLEAR cycle until frame_done is seen.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (frame_done !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 300) begin
      failures++;
      $display("FAIL wait_done timeout: frame_done not seen within %0d cycles", cyc);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (grid !== '0) begin failures++; $display("FAIL reset_grid got=%h exp=0", grid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    checks++; if (seg_rd !== 1'b0 || seg_addr !== 6'd0) begin failures++; $display("FAIL reset_seg got rd=%b addr=%0d exp rd=0 addr=0", seg_rd, seg_addr); end
    checks++; if (self_hit !== 1'b0 || food_eaten !== 1'b0) begin failures++; $display("FAIL reset_flags got sh=%b fe=%b exp 0 0", self_hit, food_eaten); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int cyc, fd0;
    for (int i = 0; i < 10; i++) mem[i] = {4'(i), 4'(i + 1)};
    addr_log.delete();
    do_start(10, 8'h00, 1'b0);
    e = sb.pop_back();
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    fd0 = fd_cnt;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (grid !== '0) begin failures++; $display("FAIL mid_grid got=%h exp=0", grid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    checks++; if (fd_cnt !== fd0) begin failures++; $display("FAIL mid_no_frame_done got=%0d exp=%0d", fd_cnt - fd0, 0); end
    checks++; if (grid !== '0) begin failures++; $display("FAIL mid_grid_hold got=%h exp=0", grid); end
    addr_log.delete();
    do_start(10, 8'h00, 1'b0);
    wait_done(cyc);
    checks++; if (cyc !== 11) begin failures++; $display("FAIL mid_fresh_latency got=%0d exp=%0d", cyc, 11); end
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (grid !== e.g) begin failures++; $display("FAIL mid_fresh_grid got=%h exp=%h", grid, e.g); end
    checks++; if (self_hit !== e.sh || food_eaten !== e.fe) begin failures++; $display("FAIL mid_fresh_flags got sh=%b fe=%b exp sh=%b fe=%b", self_hit, food_eaten, e.sh, e.fe); end
    checks++; if (addr_log.size() !== 10) begin failures++; $display("FAIL mid_fresh_reads got=%0d exp=%0d", addr_log.size(), 10); end
  endtask

  task automatic test_len0;
    exp_t e;
    int cyc;
    grid_t want;
    want = '0;
    want[3][5] = 1'b1;
    addr_log.delete();
    do_start(0, 8'h35, 1'b1);
    wait_done(cyc);
    checks++; if (cyc !== 1) begin failures++; $display("FAIL len0_latency got=%0d exp=%0d", cyc, 1); end
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (grid !== want || grid !== e.g) begin failures++; $display("FAIL len0_grid got=%h exp=%h", grid, want); end
    checks++; if (self_hit !== 1'b0 || food_eaten !== 1'b0) begin failures++; $display("FAIL len0_flags got sh=%b fe=%b exp 0 0", self_hit, food_eaten); end
    checks++; if (addr_log.size() !== 0) begin failures++; $display("FAIL len0_reads got=%0d exp=0", addr_log.size()); end
  endtask

  task automatic test_basic;
    exp_t e;
    int cyc;
    grid_t want;
    mem[0] = 8'h88; mem[1] = 8'h87; mem[2] = 8'h86;
    want = '0;
    want[8][8] = 1'b1; want[8][7] = 1'b1; want[8][6] = 1'b1; want[2][2] = 1'b1;
    addr_log.delete();
    do_start(3, 8'h22, 1'b1);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
    wait_done(cyc);
    checks++; if (cyc !== 4) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", cyc, 4); end
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (grid !== want || grid !== e.g) begin failures++; $display("FAIL basic_grid got=%h exp=%h", grid, want); end
    checks++; if (self_hit !== 1'b0 || food_eaten !== 1'b0) begin failures++; $display("FAIL basic_flags got sh=%b fe=%b exp 0 0", self_hit, food_eaten); end
    checks++; if (addr_log.size() !== 3) begin failures++; $display("FAIL basic_reads got=%0d exp=3", addr_log.size()); end
    for (int i = 0; i < addr_log.size() && i < 3; i++) begin
      checks++; if (addr_log[i] !== 6'(i)) begin failures++; $display("FAIL basic_addr[%0d] got=%0d exp=%0d", i, addr_log[i], i); end
    end
  endtask

  task automatic test_hits;
    exp_t e;
    int cyc;
    logic [7:0] segs [0:3];
    logic [7:0] foods [0:3];
    logic       fvs   [0:3];
    int         lens  [0:3];
    logic       want_sh [0:3];
    logic       want_fe [0:3];
    // head on food, no overlap / head on food, seg3 over seg1 /
    // non-head on food / head on undrawn food
    lens[0] = 4; foods[0] = 8'h44; fvs[0] = 1'b1; want_sh[0] = 1'b0; want_fe[0] = 1'b1;
    lens[1] = 4; foods[1] = 8'h44; fvs[1] = 1'b1; want_sh[1] = 1'b1; want_fe[1] = 1'b1;
    lens[2] = 3; foods[2] = 8'h44; fvs[2] = 1'b1; want_sh[2] = 1'b0; want_fe[2] = 1'b0;
    lens[3] = 2; foods[3] = 8'h44; fvs[3] = 1'b0; want_sh[3] = 1'b0; want_fe[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin mem[0] = 8'h44; mem[1] = 8'h55; mem[2] = 8'h54; mem[3] = 8'h65; end
        1: begin mem[0] = 8'h44; mem[1] = 8'h55; mem[2] = 8'h54; mem[3] = 8'h55; end
        2: begin mem[0] = 8'h11; mem[1] = 8'h44; mem[2] = 8'h12; end
        default: begin mem[0] = 8'h44; mem[1] = 8'h45; end
      endcase
      segs[k] = mem[0];
      do_start(lens[k], foods[k], fvs[k]);
      wait_done(cyc);
      checks++; if (cyc !== lens[k] + 1) begin failures++; $display("FAIL hits%0d_latency got=%0d exp=%0d", k, cyc, lens[k] + 1); end
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (grid !== e.g) begin failures++; $display("FAIL hits%0d_grid got=%h exp=%h", k, grid, e.g); end
      checks++; if (self_hit !== want_sh[k] || e.sh !== want_sh[k]) begin failures++; $display("FAIL hits%0d_self_hit got=%b exp=%b", k, self_hit, want_sh[k]); end
      checks++; if (food_eaten !== want_fe[k] || e.fe !== want_fe[k]) begin failures++; $display("FAIL hits%0d_food_eaten got=%b exp=%b (head %h)", k, food_eaten, want_fe[k], segs[k]); end
    end
  endtask

  task automatic test_clamp;
    exp_t e;
    int cyc;
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    addr_log.delete();
    do_start(100, 8'hF0, 1'b1);
    wait_done(cyc);
    checks++; if (cyc !== 65) begin failures++; $display("FAIL clamp_latency got=%0d exp=%0d", cyc, 65); end
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (grid !== e.g) begin failures++; $display("FAIL clamp_grid got=%h exp=%h", grid, e.g); end
    checks++; if (self_hit !== e.sh || food_eaten !== e.fe) begin failures++; $display("FAIL clamp_flags got sh=%b fe=%b exp sh=%b fe=%b", self_hit, food_eaten, e.sh, e.fe); end
    checks++; if (addr_log.size() !== 64) begin failures++; $display("FAIL clamp_reads got=%0d exp=64", addr_log.size()); end
    for (int i = 0; i < addr_log.size() && i < 64; i++) begin
      if (addr_log[i] !== 6'(i)) begin
        checks++; failures++;
        $display("FAIL clamp_addr[%0d] got=%0d exp=%0d", i, addr_log[i], i);
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    grid_t prev_grid;
    logic prev_fd;
    int nfd, npop, last_t, fd0, hold_viol;
    mem[0] = 8'hA1; mem[1] = 8'hA2; mem[2] = 8'hB2; mem[3] = 8'hC2; mem[4] = 8'hC3;
    for (int k = 0; k < 3; k++) sb.push_back(model(5, 8'h0F, 1'b1));
    @(negedge clk);
    snake_len  = 7'd5;
    food_pos   = 8'h0F;
    food_valid = 1'b1;
    start      = 1'b1;
    prev_grid  = grid;
    prev_fd    = 1'b0;
    nfd = 0; npop = 0; last_t = -1; hold_viol = 0;
    fd0 = fd_cnt;
    for (int t = 0; t < 80 && npop < 3; t++) begin
      @(negedge clk);
      if (prev_fd) begin
        e = sb.pop_front();
        npop++;
        checks++; if (grid !== e.g) begin failures++; $display("FAIL b2b_grid[%0d] got=%h exp=%h", npop, grid, e.g); end
      end else if (grid !== prev_grid) begin
        hold_viol++;
      end
      if (frame_done === 1'b1) begin
        if (last_t >= 0) begin
          checks++; if (t - last_t !== 8) begin failures++; $display("FAIL b2b_period got=%0d exp=%0d", t - last_t, 8); end
        end
        last_t = t;
        nfd++;
        if (nfd == 3) start = 1'b0;
      end
      prev_fd   = frame_done;
      prev_grid = grid;
    end
    start = 1'b0;
    checks++; if (npop !== 3) begin failures++; $display("FAIL b2b_frames got=%0d exp=3", npop); end
    checks++; if (hold_viol !== 0) begin failures++; $display("FAIL b2b_grid_hold got=%0d changes exp=0", hold_viol); end
    repeat (12) @(negedge clk);
    checks++; if (fd_cnt - fd0 !== 3) begin failures++; $display("FAIL b2b_frame_count got=%0d exp=3", fd_cnt - fd0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", busy); end
    while (sb.size() > 0) e = sb.pop_front();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    test_reset;
    test_reset_mid;
    test_len0;
    test_basic;
    test_hits;
    test_clamp;
    test_back_to_back;
    checks++; if (addr_viol !== 0) begin failures++; $display("FAIL seg_addr_idle got=%0d nonzero cycles exp=0", addr_viol); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/snake_grid_renderer.md
Name: snake_grid_renderer

Overview:
- Frame builder directly upstream of the LED matrix driver.
- On each frame tick it reads the snake segment list and the food position, and rasterises them into a 16x16 bitmap.
- It publishes the bitmap atomically on the `grid` output, which the matrix driver consumes.
- While plotting it also detects self-overlap and food pickup, for use by the game logic.

Parameters:
- MAX_LEN, 64: maximum segments rendered; longer lengths are clamped.
- LEN_W, 7: width of snake_len, equal to $clog2(MAX_LEN+1).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  frame tick; sampled only in IDLE.
- snake_len  in  LEN_W  number of segments to render, head is index 0.
- food_pos  in  8  {row[3:0], col[3:0]}.
- food_valid  in  1  draw food this frame.
- seg_rd  out  1  segment memory read strobe.
- seg_addr  out  6  segment index to read.
- seg_data  in  8  {row,col} of segment seg_addr; valid the cycle after seg_rd.
- grid  out  [15:0][15:0]  grid[row][col], 1 = LED on; changes only at COMMIT.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse in COMMIT.
- self_hit  out  1  some segment landed on a pixel already set by an earlier segment.
- food_eaten  out  1  head (index 0) landed on the food pixel.

Behaviour:
- Reset (async, any state):
  - state = IDLE.
  - grid, work buffer, self_hit, food_eaten = 0.
  - busy, frame_done, seg_rd, seg_addr = 0.
  - An in-progress frame is discarded; grid is never partially updated.
- States: IDLE, CLEAR, DRAW, COMMIT.
- IDLE:
  - If start = 1, latch len = min(snake_len, MAX_LEN), food_pos and food_valid.
  - Go to CLEAR.
  - start in any other state is ignored, with no queuing.
- CLEAR, exactly 1 cycle:
  - work <= all zeros, except work[food.row][food.col] = food_valid.
  - Clear the internal hit flags.
  - If len > 0: seg_rd = 1, seg_addr = 0, go to DRAW with j = 1.
  - If len = 0: go to COMMIT.
- DRAW, exactly len cycles, j = 1..len:
  - Plot seg_data, which is the data for index j-1.
  - If work[r][c] was already 1 before this plot and (r,c) != food pixel, set hit_self.
  - If j = 1 and food_valid and (r,c) == food pixel, set hit_food.
  - Set work[r][c] = 1.
  - If j < len: seg_rd = 1, seg_addr = j. Otherwise seg_rd = 0 and go to COMMIT.
  - A non-head segment on the food pixel is neither a hit nor eaten.
- COMMIT, 1 cycle:
  - grid <= work (includes the last DRAW plot).
  - self_hit <= hit_self; food_eaten <= hit_food.
  - frame_done = 1; go to IDLE.
- Latency:
  - start sampled at edge k.
  - frame_done is high in the cycle after edge k+len+1.
  - grid is updated at edge k+len+2.
  - Back-to-back start gives one frame per len+3 cycles.
- self_hit and food_eaten hold until the next COMMIT or reset.
- Coordinates are 4-bit, so every position is in range and no wrap handling is needed.
- seg_addr is 0 whenever seg_rd = 0.

Decomposition:
- snake_pkg (shared with game logic and matrix driver):
  - GRID_N = 16.
  - pos_t packed struct {logic [3:0] row; logic [3:0] col}.
  - grid_t = logic [GRID_N-1:0][GRID_N-1:0].
  - Renderer state enum.
- Single module; no sub-module.
- Segment storage is the game logic's memory, outside this block.

Test Plan:
- Reset mid-DRAW (len=10, reset asserted at j=4) -> grid stays 0, busy=0 next cycle, no frame_done; a fresh start renders correctly.
- len=0, food_valid=1, food=(3,5), start -> frame_done 2 cycles later; grid has only bit [3][5] set; self_hit=0, food_eaten=0.
- len=3, segments (8,8),(8,7),(8,6), food (2,2) -> grid bits [8][8],[8][7],[8][6],[2][2] set; seg_addr sequence 0,1,2; frame_done at cycle len+2.
- len=4, head (4,4) equals food (4,4) -> food_eaten=1, self_hit=0; segment 3 also at (5,5) as segment 1 -> self_hit=1.
- start held high during a len=5 render -> exactly one frame_done per len+3 cycles; mid-render start ignored; grid constant between commits.
- snake_len=100 -> exactly 64 reads (seg_addr 0..63), then COMMIT.
